// File: rtl/sdrx_datablk_pkg.sv
// Shared types and helpers for the SD data-block receiver.
package sdrx_pkg;
  typedef enum logic [2:0] {IDLE, START, START2, DATA, CRC, END} state_t;

  localparam logic [15:0] CRC_POLY_DEF = 16'h1021;
  localparam int          NUM_CRC      = 8;

  // One MSB-first CRC-16 step with the data bit folded into the feedback.
  function automatic logic [15:0] stepcrc(input logic [15:0] prior, input logic b,
                                          input logic [15:0] poly);
    return {prior[14:0], 1'b0} ^ ((prior[15] ^ b) ? poly : 16'h0000);
  endfunction

  function automatic logic [4:0] word_strobes(input logic w4);
    return w4 ? 5'd7 : 5'd31;
  endfunction
endpackage

// File: rtl/sdrx_datablk_crc16.sv
// One lane/phase CRC-16 register: accumulates data bits, then shifts out MSB-first.
module sdrx_crc16
  import sdrx_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic shift,
  input  logic din,
  output logic msb
);
  logic [15:0] crc;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)  crc <= '0;
    else if (step)      crc <= stepcrc(crc, din, POLY);
    else if (shift)     crc <= {crc[14:0], 1'b0};
  end

  assign msb = crc[15];
endmodule

// File: rtl/sdrx_datablk.sv
// SD/SDIO data-block receiver: start bit, word reassembly, per-lane/phase CRC-16, end bit.
module sdrx_datablk
  import sdrx_pkg::*;
#(
  parameter logic [15:0] CRC_POLY  = CRC_POLY_DEF,
  parameter int          LGTIMEOUT = 24
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic                 i_width,
  input  logic                 i_ddr,
  input  logic [12:0]          i_length,
  input  logic [LGTIMEOUT-1:0] i_timeout,
  input  logic                 i_sample,
  input  logic [3:0]           i_dat,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [31:0]          o_data,
  output logic                 o_last,
  output logic                 o_done,
  output logic                 o_crc_err,
  output logic                 o_frame_err,
  output logic                 o_timeout
);
  state_t               state, state_nxt;
  logic                 width_r, ddr_r, phase;
  logic [15:0]          rem;
  logic [4:0]           wcnt;
  logic [5:0]           crc_cnt;
  logic [LGTIMEOUT-1:0] tmo_cnt, tmo_nxt;
  logic [31:0]          shreg, sh_nxt;
  logic [3:0]           act;
  logic                 start_ok, sbit, tmo_hit, crc_miss;
  logic [NUM_CRC-1:0]   crc_step, crc_shift, crc_msb;

  assign act      = width_r ? 4'hF : 4'h1;
  assign start_ok = i_start && (state == IDLE);
  assign sbit     = i_sample && !i_dat[0];
  assign tmo_nxt  = tmo_cnt + LGTIMEOUT'(1);
  // A start bit arriving on the expiry clock wins over the timeout.
  assign tmo_hit  = (state == START) && !sbit && (i_timeout != '0) && (tmo_nxt == i_timeout);
  assign sh_nxt   = width_r ? {shreg[27:0], i_dat} : {shreg[30:0], i_dat[0]};
  assign crc_miss = |((i_dat ^ (phase ? crc_msb[7:4] : crc_msb[3:0])) & act);

  // crc[lane + 4*phase]; inactive lanes stay cleared.
  generate
    for (genvar k = 0; k < NUM_CRC; k++) begin : g_crc
      localparam int   LANE = k % 4;
      localparam logic PH   = (k >= 4);
      logic sel;
      assign sel          = i_sample && act[LANE] && (phase == PH);
      assign crc_step[k]  = sel && (state == DATA);
      assign crc_shift[k] = sel && (state == CRC);
      sdrx_crc16 #(.POLY(CRC_POLY)) u_crc (
        .clk(i_clk), .rst_n(i_reset_n), .clr(start_ok),
        .step(crc_step[k]), .shift(crc_shift[k]), .din(i_dat[LANE]), .msb(crc_msb[k])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = START;
      START:   if (sbit) state_nxt = ddr_r ? START2 : DATA;
               else if (tmo_hit) state_nxt = IDLE;
      START2:  if (i_sample) state_nxt = DATA;
      DATA:    if (i_sample && rem == 16'd1) state_nxt = CRC;
      CRC:     if (i_sample && crc_cnt == 6'd1) state_nxt = END;
      END:     if (i_sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      width_r <= 1'b0; ddr_r <= 1'b0; phase <= 1'b0;
      rem <= '0; wcnt <= '0; crc_cnt <= '0; tmo_cnt <= '0; shreg <= '0;
      o_valid <= 1'b0; o_data <= '0; o_last <= 1'b0; o_done <= 1'b0;
      o_crc_err <= 1'b0; o_frame_err <= 1'b0; o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          width_r     <= i_width;
          ddr_r       <= i_ddr;
          rem         <= i_width ? {2'b00, i_length, 1'b0} : {i_length, 3'b000};
          wcnt        <= word_strobes(i_width);
          tmo_cnt     <= '0;
          phase       <= 1'b0;
          o_crc_err   <= 1'b0;
          o_frame_err <= 1'b0;
          o_timeout   <= 1'b0;
        end
        START: begin
          tmo_cnt <= tmo_nxt;
          if (sbit) begin
            if (width_r && i_dat[3:1] != 3'b000) o_frame_err <= 1'b1;
          end else if (tmo_hit) begin
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
          end
        end
        START2: if (i_sample && (i_dat & act) != 4'h0) o_frame_err <= 1'b1;
        DATA: if (i_sample) begin
          shreg <= sh_nxt;
          phase <= ddr_r & ~phase;
          rem   <= rem - 16'd1;
          if (wcnt == 5'd0) begin
            o_valid <= 1'b1;
            o_data  <= sh_nxt;
            o_last  <= (rem == 16'd1);
            wcnt    <= word_strobes(width_r);
          end else begin
            wcnt <= wcnt - 5'd1;
          end
          if (rem == 16'd1) begin
            crc_cnt <= ddr_r ? 6'd32 : 6'd16;
            phase   <= 1'b0;
          end
        end
        CRC: if (i_sample) begin
          phase   <= ddr_r & ~phase;
          crc_cnt <= crc_cnt - 6'd1;
          if (crc_miss) o_crc_err <= 1'b1;
        end
        END: if (i_sample) begin
          if ((i_dat & act) != act) o_frame_err <= 1'b1;
          o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdrx_datablk.sv
// Bench for sdrx_datablk: a card-side block generator with long-division CRCs and a word scoreboard.
module tb_sdrx_datablk;
  localparam int LGT = 24;

  logic           i_clk = 1'b0, i_reset_n = 1'b0, i_start = 1'b0;
  logic           i_width = 1'b0, i_ddr = 1'b0, i_sample = 1'b0;
  logic [12:0]    i_length = 13'd4;
  logic [LGT-1:0] i_timeout = '0;
  logic [3:0]     i_dat = 4'hF;
  logic           o_busy, o_valid, o_last, o_done, o_crc_err, o_frame_err, o_timeout;
  logic [31:0]    o_data;

  int          errors = 0, checks = 0;
  int          vld_cnt = 0, done_cnt = 0;
  logic [31:0] got [0:2047];
  logic [2:0]  dflags = '0;     // {crc, frame, timeout} seen at the last done
  logic [2:0]  exp_flags = '0;
  logic [32:0] exp_q [$];       // {last, word}
  logic [31:0] wd [0:1023];

  sdrx_datablk #(.LGTIMEOUT(LGT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_width(i_width),
    .i_ddr(i_ddr), .i_length(i_length), .i_timeout(i_timeout), .i_sample(i_sample),
    .i_dat(i_dat), .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .o_done(o_done), .o_crc_err(o_crc_err), .o_frame_err(o_frame_err), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CRC as remainder of (message * x^16) mod g, fed one bit at a time.
  function automatic logic [16:0] div_step(input logic [16:0] r, input logic b);
    logic [16:0] t;
    t = {r[15:0], b};
    if (t[16]) t = t ^ 17'h11021;
    return t;
  endfunction

  function automatic logic [15:0] div_finish(input logic [16:0] r);
    for (int i = 0; i < 16; i++) r = div_step(r, 1'b0);
    return r[15:0];
  endfunction

  always @(negedge i_clk) begin
    logic [32:0] e;
    if (o_valid === 1'b1) begin
      if (vld_cnt < 2048) got[vld_cnt] = o_data;
      vld_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", {31'b0, o_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("word", o_data, e[31:0]);
        check("last", {31'b0, o_last}, {31'b0, e[32]});
      end
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      dflags = {o_crc_err, o_frame_err, o_timeout};
      check("done_flags", {29'b0, dflags}, {29'b0, exp_flags});
      check("words_left", exp_q.size(), 32'd0);
      check("busy_at_done", {31'b0, o_busy}, 32'd0);
    end
  end

  task automatic strobe(input logic [3:0] v, input int gap, input bit st);
    i_sample = 1'b1;
    i_dat    = v;
    if (st) begin i_start = 1'b1; i_length = 13'd4; end
    @(posedge i_clk); #1;
    i_sample = 1'b0;
    i_start  = 1'b0;
    for (int g = 1; g < gap; g++) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_start(input int len, input bit w4, input bit ddr, input int tmo);
    i_start = 1'b1; i_length = 13'(len); i_width = w4; i_ddr = ddr; i_timeout = LGT'(tmo);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Card side of one block after the start command; stop_words>0 returns early.
  task automatic send_body(input int nwords, input bit w4, input bit ddr, input int gap,
                           input int flip_k, input logic [3:0] endv, input int stop_words,
                           input int bs_at);
    logic [16:0] rr [8];
    logic [15:0] c [8];
    logic [3:0]  act, v;
    int s, p, idx, d0, v0, n;
    act = w4 ? 4'hF : 4'h1;
    for (int k = 0; k < 8; k++) rr[k] = '0;
    exp_flags = {flip_k >= 0, (endv & act) != act, 1'b0};
    for (int i = 0; i < nwords; i++) exp_q.push_back({(i == nwords - 1), wd[i]});
    d0 = done_cnt; v0 = vld_cnt;
    strobe(4'hF, gap, 0);
    strobe(4'hF, gap, 0);
    strobe(w4 ? 4'h0 : 4'hE, gap, 0);
    if (ddr) strobe(w4 ? 4'h0 : 4'hE, gap, 0);
    s = 0;
    for (int i = 0; i < nwords; i++) begin
      for (int b = 0; b < (w4 ? 8 : 32); b++) begin
        if (w4) v = wd[i][31 - 4*b -: 4];
        else    v = {3'b111, wd[i][31 - b]};
        p = ddr ? s % 2 : 0;
        for (int l = 0; l < 4; l++) if (act[l]) rr[l + 4*p] = div_step(rr[l + 4*p], v[l]);
        strobe(v, gap, s == bs_at);
        s++;
        if (stop_words > 0 && vld_cnt - v0 >= stop_words) return;
      end
    end
    for (int k = 0; k < 8; k++) c[k] = div_finish(rr[k]);
    if (flip_k >= 0) c[flip_k] = c[flip_k] ^ 16'h8000;
    for (int j = 0; j < (ddr ? 32 : 16); j++) begin
      p   = ddr ? j % 2 : 0;
      idx = ddr ? 15 - j / 2 : 15 - j;
      v   = 4'hF;
      for (int l = 0; l < 4; l++) if (act[l]) v[l] = c[l + 4*p][idx];
      strobe(v, gap, 0);
    end
    strobe(endv, gap, 0);
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(posedge i_clk); n++; end
    check("done_seen", done_cnt - d0, 32'd1);
  endtask

  initial begin
    logic [16:0] r;
    logic [71:0] msg;
    int v0, d0, early;

    // Model pin: CRC-16/XMODEM check value of "123456789".
    msg = "123456789";
    r = '0;
    for (int i = 0; i < 72; i++) r = div_step(r, msg[71 - i]);
    check("model_crc_pin", {16'b0, div_finish(r)}, 32'h31C3);

    repeat (3) @(posedge i_clk);
    #1;
    check("reset_ctrl", {25'b0, o_busy, o_valid, o_last, o_done, o_crc_err, o_frame_err, o_timeout}, 32'd0);
    check("reset_data", o_data, 32'd0);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // 1-bit SDR, 512 bytes of 00 01 02 03 ..., strobe every 2nd clock
    for (int i = 0; i < 128; i++) wd[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
    v0 = vld_cnt;
    do_start(512, 0, 0, 1000);
    send_body(128, 0, 0, 2, -1, 4'hF, 0, -1);
    check("t1_first_word", got[v0], 32'h00010203);
    check("t1_word_count", vld_cnt - v0, 32'd128);
    check("t1_flags", {29'b0, dflags}, 32'd0);

    // 4-bit DDR, 8 bytes, back-to-back strobes
    wd[0] = 32'hDEADBEEF; wd[1] = 32'h01234567;
    v0 = vld_cnt;
    do_start(8, 1, 1, 1000);
    send_body(2, 1, 1, 1, -1, 4'hF, 0, -1);
    check("t2_word0", got[v0], 32'hDEADBEEF);
    check("t2_word1", got[v0 + 1], 32'h01234567);
    check("t2_flags", {29'b0, dflags}, 32'd0);

    // same block, lane 2 phase 1 CRC corrupted
    do_start(8, 1, 1, 1000);
    send_body(2, 1, 1, 1, 6, 4'hF, 0, -1);
    check("t2_crc_err", {29'b0, dflags}, 32'b100);

    // 4-bit SDR with DAT1 low on the end bit
    for (int i = 0; i < 4; i++) wd[i] = 32'hA5000000 ^ (i * 32'h01030507);
    do_start(16, 1, 0, 1000);
    send_body(4, 1, 0, 3, -1, 4'hD, 0, -1);
    check("t3_frame_err", {29'b0, dflags}, 32'b010);

    // timeout after exactly 100 clocks with DAT idle high
    exp_flags = 3'b001;
    d0 = done_cnt;
    do_start(8, 1, 0, 100);
    early = 0;
    for (int k = 1; k < 100; k++) begin
      @(posedge i_clk); #1;
      if (o_done !== 1'b0 || o_timeout !== 1'b0) early++;
    end
    check("t4_no_early_done", early, 32'd0);
    @(posedge i_clk); #1;
    check("t4_done_timeout_busy", {29'b0, o_done, o_timeout, o_busy}, 32'b110);
    @(posedge i_clk); #1;
    check("t4_done_count", done_cnt - d0, 32'd1);

    // timeout disabled: a long wait, then the block still arrives
    for (int i = 0; i < 4; i++) wd[i] = 32'h13579BDF + i * 32'h11111111;
    d0 = done_cnt;
    do_start(16, 0, 0, 0);
    repeat (20000) @(posedge i_clk);
    #1;
    check("t5_no_timeout", {31'b0, o_busy}, 32'd1);
    check("t5_no_done", done_cnt - d0, 32'd0);
    send_body(4, 0, 0, 1, -1, 4'hF, 0, -1);
    check("t5_flags", {29'b0, dflags}, 32'd0);

    // reset after the 3rd word of a 512-byte block
    for (int i = 0; i < 128; i++) wd[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
    v0 = vld_cnt;
    do_start(512, 0, 0, 1000);
    send_body(128, 0, 0, 2, -1, 4'hF, 3, -1);
    check("t6_words_before_reset", vld_cnt - v0, 32'd3);
    exp_q.delete();
    i_reset_n = 1'b0;
    @(posedge i_clk); #1;
    check("t6_reset_ctrl", {25'b0, o_busy, o_valid, o_last, o_done, o_crc_err, o_frame_err, o_timeout}, 32'd0);
    check("t6_reset_data", o_data, 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    v0 = vld_cnt; d0 = done_cnt;
    for (int i = 0; i < 40; i++) strobe(4'(i), 1, 0);
    check("t6_no_valid_after", vld_cnt - v0, 32'd0);
    check("t6_no_done_after", done_cnt - d0, 32'd0);
    for (int i = 0; i < 4; i++) wd[i] = 32'hCAFE0000 + i;
    v0 = vld_cnt;
    do_start(16, 1, 0, 1000);
    send_body(4, 1, 0, 1, -1, 4'hF, 0, -1);
    check("t6_clean_first", got[v0], 32'hCAFE0000);
    check("t6_clean_flags", {29'b0, dflags}, 32'd0);

    // i_start mid-DATA (with a different length) must be ignored
    for (int i = 0; i < 8; i++) wd[i] = 32'h0F1E2D3C ^ (i << 4);
    v0 = vld_cnt;
    do_start(32, 1, 0, 1000);
    send_body(8, 1, 0, 1, -1, 4'hF, 0, 10);
    check("t7_word_count", vld_cnt - v0, 32'd8);
    check("t7_flags", {29'b0, dflags}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
